// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared pipeline definitions for the hazard/stall controller:
// controller FSM states and the register-index width.
package pipe_hazard_ctrl_pkg;

    localparam int REG_IDX_W = 5;

    typedef enum logic [0:0] {
        RUN      = 1'b0,
        LU_STALL = 1'b1
    } hz_state_e;

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Hazard-detect inputs, pipeline-register controls and performance counters
// exchanged between the pipeline datapath and the hazard controller.
interface pipe_hazard_ctrl_if
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter int CNT_W = 32
) ();

    logic [REG_IDX_W-1:0] d_rs1;
    logic [REG_IDX_W-1:0] d_rs2;
    logic                 d_rs1_used;
    logic                 d_rs2_used;
    logic [REG_IDX_W-1:0] e_rd;
    logic                 e_load;
    logic                 jb;
    logic                 m_mem_req;
    logic                 m_mem_ready;
    logic                 stall_pc;
    logic                 stall_d;
    logic                 flush_d;
    logic                 bubble_e;
    logic                 hold_e;
    logic                 hold_m;
    logic                 bubble_w;
    logic [CNT_W-1:0]     stall_cnt;
    logic [CNT_W-1:0]     flush_cnt;

    modport slave (
        input  d_rs1, d_rs2, d_rs1_used, d_rs2_used, e_rd, e_load, jb,
               m_mem_req, m_mem_ready,
        output stall_pc, stall_d, flush_d, bubble_e, hold_e, hold_m, bubble_w,
               stall_cnt, flush_cnt
    );

    modport master (
        output d_rs1, d_rs2, d_rs1_used, d_rs2_used, e_rd, e_load, jb,
               m_mem_req, m_mem_ready,
        input  stall_pc, stall_d, flush_d, bubble_e, hold_e, hold_m, bubble_w,
               stall_cnt, flush_cnt
    );

endinterface

// File: rtl/pipe_hazard_ctrl_perf_counter.sv
// Free-running wrap-around event counter with increment enable.
module pipe_perf_counter #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc_en,
    output logic [CNT_W-1:0] cnt
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Next count: wraps naturally modulo 2^CNT_W.
    always_comb begin
        cnt_d = cnt_q;
        if (inc_en) begin
            cnt_d = cnt_q + CNT_W'(1);
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Count register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Hazard and stall controller for the 5-stage RV32I pipeline: load-use stalls,
// EX-resolved branch flushes and MEM wait-state freezes, plus perf counters.
module pipe_hazard_ctrl
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter int LOAD_USE_CYCLES = 1,
    parameter int CNT_W           = 32
) (
    input  logic               clk,
    input  logic               rst,
    pipe_hazard_ctrl_if.slave  hz
);

    localparam logic [1:0] LU_REM_INIT = 2'(LOAD_USE_CYCLES - 1);

    hz_state_e  state_q, state_d;
    logic [1:0] lu_rem_q, lu_rem_d;

    logic freeze_s;
    logic lu_hit_s;
    logic stall_pc_s, stall_d_s, flush_d_s, bubble_e_s;
    logic hold_e_s, hold_m_s, bubble_w_s;
    logic flush_inc_s;

    assign freeze_s = hz.m_mem_req & ~hz.m_mem_ready;
    assign lu_hit_s = hz.e_load & (hz.e_rd != REG_IDX_W'(0)) &
                      ((hz.d_rs1_used & (hz.d_rs1 == hz.e_rd)) |
                       (hz.d_rs2_used & (hz.d_rs2 == hz.e_rd)));

    // Prioritised control decode and FSM next state.
    always_comb begin
        state_d     = state_q;
        lu_rem_d    = lu_rem_q;
        stall_pc_s  = 1'b0;
        stall_d_s   = 1'b0;
        flush_d_s   = 1'b0;
        bubble_e_s  = 1'b0;
        hold_e_s    = 1'b0;
        hold_m_s    = 1'b0;
        bubble_w_s  = 1'b0;
        flush_inc_s = 1'b0;
        if (freeze_s) begin
            // Whole front of the pipe waits; FSM and pending bubbles are kept.
            stall_pc_s = 1'b1;
            stall_d_s  = 1'b1;
            hold_e_s   = 1'b1;
            hold_m_s   = 1'b1;
            bubble_w_s = 1'b1;
        end else if (hz.jb) begin
            // Wrong-path ID instruction is discarded, so any pending stall goes too.
            flush_d_s   = 1'b1;
            bubble_e_s  = 1'b1;
            flush_inc_s = 1'b1;
            state_d     = RUN;
            lu_rem_d    = 2'd0;
        end else if (state_q == LU_STALL) begin
            stall_pc_s = 1'b1;
            stall_d_s  = 1'b1;
            bubble_e_s = 1'b1;
            lu_rem_d   = lu_rem_q - 2'd1;
            if (lu_rem_q == 2'd1) begin
                state_d = RUN;
            end else begin
                state_d = LU_STALL;
            end
        end else if (lu_hit_s) begin
            stall_pc_s = 1'b1;
            stall_d_s  = 1'b1;
            bubble_e_s = 1'b1;
            if (LOAD_USE_CYCLES > 1) begin
                state_d  = LU_STALL;
                lu_rem_d = LU_REM_INIT;
            end else begin
                state_d  = RUN;
                lu_rem_d = 2'd0;
            end
        end else begin
            state_d  = state_q;
            lu_rem_d = lu_rem_q;
        end
    end

    // FSM state and remaining-bubble register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= RUN;
            lu_rem_q <= 2'd0;
        end else begin
            state_q  <= state_d;
            lu_rem_q <= lu_rem_d;
        end
    end

    assign hz.stall_pc = stall_pc_s;
    assign hz.stall_d  = stall_d_s;
    assign hz.flush_d  = flush_d_s;
    assign hz.bubble_e = bubble_e_s;
    assign hz.hold_e   = hold_e_s;
    assign hz.hold_m   = hold_m_s;
    assign hz.bubble_w = bubble_w_s;

    pipe_perf_counter #(.CNT_W(CNT_W)) u_stall_cnt (
        .clk    (clk),
        .rst    (rst),
        .inc_en (stall_pc_s),
        .cnt    (hz.stall_cnt)
    );

    pipe_perf_counter #(.CNT_W(CNT_W)) u_flush_cnt (
        .clk    (clk),
        .rst    (rst),
        .inc_en (flush_inc_s),
        .cnt    (hz.flush_cnt)
    );

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: a table of single-cycle vectors plus
// hand-written multi-cycle sequences across three parameterisations.
module tb_pipe_hazard_ctrl;

    logic clk;
    logic rst;

    int n_pass;
    int n_total;

    pipe_hazard_ctrl_if #(.CNT_W(32)) if1 ();
    pipe_hazard_ctrl_if #(.CNT_W(32)) if2 ();
    pipe_hazard_ctrl_if #(.CNT_W(4))  if3 ();

    pipe_hazard_ctrl #(.LOAD_USE_CYCLES(1), .CNT_W(32)) dut1 (.clk(clk), .rst(rst), .hz(if1));
    pipe_hazard_ctrl #(.LOAD_USE_CYCLES(2), .CNT_W(32)) dut2 (.clk(clk), .rst(rst), .hz(if2));
    pipe_hazard_ctrl #(.LOAD_USE_CYCLES(3), .CNT_W(4))  dut3 (.clk(clk), .rst(rst), .hz(if3));

    // {stall_pc, stall_d, flush_d, bubble_e, hold_e, hold_m, bubble_w}
    logic [6:0] ctrl1, ctrl2, ctrl3;
    assign ctrl1 = {if1.stall_pc, if1.stall_d, if1.flush_d, if1.bubble_e, if1.hold_e, if1.hold_m, if1.bubble_w};
    assign ctrl2 = {if2.stall_pc, if2.stall_d, if2.flush_d, if2.bubble_e, if2.hold_e, if2.hold_m, if2.bubble_w};
    assign ctrl3 = {if3.stall_pc, if3.stall_d, if3.flush_d, if3.bubble_e, if3.hold_e, if3.hold_m, if3.bubble_w};

    localparam logic [6:0] C_IDLE   = 7'b0000000;
    localparam logic [6:0] C_LU     = 7'b1101000;
    localparam logic [6:0] C_FLUSH  = 7'b0011000;
    localparam logic [6:0] C_FREEZE = 7'b1100111;

    typedef struct {
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic       u1;
        logic       u2;
        logic [4:0] rd;
        logic       ld;
        logic       jb;
        logic       req;
        logic       rdy;
        logic [6:0] exp;
    } vec_t;

    vec_t vt [12];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic set_in(input logic [4:0] rs1, input logic [4:0] rs2, input logic u1,
                          input logic u2, input logic [4:0] rd, input logic ld,
                          input logic jb, input logic req, input logic rdy);
        if1.d_rs1 = rs1; if1.d_rs2 = rs2; if1.d_rs1_used = u1; if1.d_rs2_used = u2;
        if1.e_rd = rd; if1.e_load = ld; if1.jb = jb; if1.m_mem_req = req; if1.m_mem_ready = rdy;
        if2.d_rs1 = rs1; if2.d_rs2 = rs2; if2.d_rs1_used = u1; if2.d_rs2_used = u2;
        if2.e_rd = rd; if2.e_load = ld; if2.jb = jb; if2.m_mem_req = req; if2.m_mem_ready = rdy;
        if3.d_rs1 = rs1; if3.d_rs2 = rs2; if3.d_rs1_used = u1; if3.d_rs2_used = u2;
        if3.e_rd = rd; if3.e_load = ld; if3.jb = jb; if3.m_mem_req = req; if3.m_mem_ready = rdy;
        #1;
    endtask

    task automatic idle();
        set_in(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic hazard();
        set_in(5'd5, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle();
        step();
        rst = 1'b0;
    endtask

    initial begin
        n_pass  = 0;
        n_total = 0;
        vt[0]  = '{5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, C_IDLE};
        vt[1]  = '{5'd5, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, C_LU};
        vt[2]  = '{5'd1, 5'd7, 1'b1, 1'b1, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0, C_LU};
        vt[3]  = '{5'd5, 5'd0, 1'b0, 1'b0, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, C_IDLE};
        vt[4]  = '{5'd5, 5'd0, 1'b1, 1'b0, 5'd5, 1'b0, 1'b0, 1'b0, 1'b0, C_IDLE};
        vt[5]  = '{5'd0, 5'd0, 1'b1, 1'b1, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, C_IDLE};
        vt[6]  = '{5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, C_FLUSH};
        vt[7]  = '{5'd9, 5'd0, 1'b1, 1'b0, 5'd9, 1'b1, 1'b1, 1'b0, 1'b0, C_FLUSH};
        vt[8]  = '{5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, C_FREEZE};
        vt[9]  = '{5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0, C_FREEZE};
        vt[10] = '{5'd3, 5'd3, 1'b0, 1'b1, 5'd3, 1'b1, 1'b0, 1'b1, 1'b1, C_LU};
        vt[11] = '{5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, C_IDLE};

        // Reset state.
        rst = 1'b1;
        idle();
        step();
        chk("reset_ctrl", 32'(ctrl1), 32'(C_IDLE));
        chk("reset_stall_cnt", if1.stall_cnt, 32'd0);
        chk("reset_flush_cnt", if1.flush_cnt, 32'd0);
        rst = 1'b0;

        // Single-cycle vectors on the LOAD_USE_CYCLES=1 instance.
        for (int i = 0; i < 12; i++) begin
            set_in(vt[i].rs1, vt[i].rs2, vt[i].u1, vt[i].u2, vt[i].rd, vt[i].ld,
                   vt[i].jb, vt[i].req, vt[i].rdy);
            chk($sformatf("vec%0d_ctrl", i), 32'(ctrl1), 32'(vt[i].exp));
            step();
        end
        idle();
        chk("vec_stall_cnt", if1.stall_cnt, 32'd5);
        chk("vec_flush_cnt", if1.flush_cnt, 32'd2);

        // LOAD_USE_CYCLES=1: exactly one stall cycle.
        do_reset();
        hazard();
        chk("lu1_stall", 32'(ctrl1), 32'(C_LU));
        step();
        idle();
        chk("lu1_after", 32'(ctrl1), 32'(C_IDLE));
        chk("lu1_stall_cnt", if1.stall_cnt, 32'd1);

        // x0 destination never stalls.
        do_reset();
        set_in(5'd0, 5'd0, 1'b1, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("x0_ctrl", 32'(ctrl1), 32'(C_IDLE));
        step();
        chk("x0_stall_cnt", if1.stall_cnt, 32'd0);

        // LOAD_USE_CYCLES=2 with a 3-cycle freeze inside the stall.
        do_reset();
        hazard();
        chk("lu2_c0", 32'(ctrl2), 32'(C_LU));
        step();
        for (int i = 0; i < 3; i++) begin
            set_in(5'd5, 5'd0, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
            chk($sformatf("lu2_freeze%0d", i), 32'(ctrl2), 32'(C_FREEZE));
            step();
        end
        set_in(5'd5, 5'd0, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1);
        chk("lu2_last", 32'(ctrl2), 32'(C_LU));
        step();
        idle();
        chk("lu2_done", 32'(ctrl2), 32'(C_IDLE));
        chk("lu2_stall_cnt", if2.stall_cnt, 32'd5);

        // Branch taken together with load-use: flush wins, no residual stall.
        do_reset();
        set_in(5'd5, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0);
        chk("jb_lu_ctrl", 32'(ctrl2), 32'(C_FLUSH));
        step();
        idle();
        chk("jb_lu_next", 32'(ctrl2), 32'(C_IDLE));
        chk("jb_lu_flush_cnt", if2.flush_cnt, 32'd1);
        chk("jb_lu_stall_cnt", if2.stall_cnt, 32'd0);

        // Branch held across a freeze is counted only once it is accepted.
        do_reset();
        set_in(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0);
        chk("jb_frz_ctrl", 32'(ctrl1), 32'(C_FREEZE));
        step();
        chk("jb_frz_flush_cnt", if1.flush_cnt, 32'd0);
        set_in(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b1);
        chk("jb_rel_ctrl", 32'(ctrl1), 32'(C_FLUSH));
        step();
        idle();
        chk("jb_rel_flush_cnt", if1.flush_cnt, 32'd1);

        // 4-bit counter wraps after 16 stall cycles.
        do_reset();
        set_in(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 17; i++) step();
        idle();
        chk("wrap_stall_cnt4", 32'(if3.stall_cnt), 32'd1);
        chk("wrap_stall_cnt32", if1.stall_cnt, 32'd17);

        // LOAD_USE_CYCLES=3 produces exactly three consecutive stalls.
        do_reset();
        hazard();
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("lu3_cyc%0d", i), 32'(if3.stall_pc), (i < 3) ? 32'd1 : 32'd0);
            step();
            idle();
        end
        chk("lu3_stall_cnt", 32'(if3.stall_cnt), 32'd3);

        // Reset in the middle of a LOAD_USE_CYCLES=3 stall.
        do_reset();
        hazard();
        step();
        idle();
        chk("rst_mid_pre", 32'(ctrl3), 32'(C_LU));
        rst = 1'b1;
        #1;
        chk("rst_mid_ctrl", 32'(ctrl3), 32'(C_IDLE));
        chk("rst_mid_stall_cnt", 32'(if3.stall_cnt), 32'd0);
        step();
        rst = 1'b0;
        step();
        chk("rst_mid_run", 32'(ctrl3), 32'(C_IDLE));

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
